// File: rtl/spu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spu_pkg
// Description : Shared SPU types, constants and small helpers for the
//               register-fetch stage and the execution unit.
// Revision    : 1.0 - initial release
// ============================================================================
package spu_pkg;

  typedef logic [0:6]   reg_addr_t;
  typedef logic [0:127] quad_t;
  typedef logic [0:10]  op_t;
  typedef logic [0:17]  imm_t;

  localparam op_t NOP_OP      = 11'b0;
  localparam int  LAT_DEFAULT = 6;
  localparam int  NUM_REGS    = 128;

  typedef struct packed {
    op_t        op;
    logic [2:0] format;
    reg_addr_t  rt_addr;
    quad_t      ra;
    quad_t      rb;
    quad_t      rc;
    imm_t       imm;
    logic       reg_write;
  } issue_t;

  function automatic logic src_hit(
    input reg_addr_t ra, input logic ua,
    input reg_addr_t rb, input logic ub,
    input reg_addr_t rc, input logic uc,
    input reg_addr_t dst, input logic dst_we
  );
    src_hit = dst_we && ((ua && ra == dst) || (ub && rb == dst) || (uc && rc == dst));
  endfunction

  // Younger stage-6 tap beats the stage-7 write bypass, which beats storage.
  function automatic quad_t fwd_sel(
    input reg_addr_t src,
    input logic wb_we,  input reg_addr_t wb_addr,  input quad_t wb_data,
    input logic int_we, input reg_addr_t int_addr, input quad_t int_data,
    input quad_t rf_data
  );
    quad_t v;
    v = rf_data;
    if (wb_we && wb_addr == src)
      v = wb_data;
    else if (int_we && int_addr == src)
      v = int_data;
    fwd_sel = v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/spu_regfile.sv
`default_nettype none
// ============================================================================
// Module      : spu_regfile
// Description : 128 x 128-bit SPU register file, three async read ports,
//               one synchronous write port, asynchronously cleared.
// Revision    : 1.0 - initial release
// ============================================================================
module spu_regfile
  import spu_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  input  reg_addr_t ra_addr,
  input  reg_addr_t rb_addr,
  input  reg_addr_t rc_addr,
  output quad_t     ra_data,
  output quad_t     rb_data,
  output quad_t     rc_data,
  input  logic      we,
  input  reg_addr_t wa,
  input  quad_t     wd
);

  quad_t r_mem [NUM_REGS];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) r_mem[i] <= '0;
    end else if (we) begin
      r_mem[wa] <= wd;
    end
  end

  assign ra_data = r_mem[ra_addr];
  assign rb_data = r_mem[rb_addr];
  assign rc_data = r_mem[rc_addr];

endmodule
`default_nettype wire

// File: rtl/rf_fwd_stage.sv
`default_nettype none
// ============================================================================
// Module      : rf_fwd_stage
// Description : SPU register fetch with stage-6/7 forwarding, RAW scoreboard
//               stall, and the registered operand bundle for execution.
// Revision    : 1.0 - initial release
// ============================================================================
module rf_fwd_stage
  import spu_pkg::*;
#(
  parameter int LAT = LAT_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       valid_dec,
  input  op_t        op_dec,
  input  logic [2:0] format_dec,
  input  reg_addr_t  rt_addr_dec,
  input  reg_addr_t  ra_addr,
  input  reg_addr_t  rb_addr,
  input  reg_addr_t  rc_addr,
  input  logic       ra_use,
  input  logic       rb_use,
  input  logic       rc_use,
  input  imm_t       imm_dec,
  input  logic       reg_write_dec,
  input  quad_t      rt_wb,
  input  reg_addr_t  rt_addr_wb,
  input  logic       reg_write_wb,
  input  quad_t      rt_int,
  input  reg_addr_t  rt_addr_int,
  input  logic       reg_write_int,
  output op_t        op,
  output logic [2:0] format,
  output reg_addr_t  rt_addr,
  output quad_t      ra,
  output quad_t      rb,
  output quad_t      rc,
  output imm_t       imm,
  output logic       reg_write,
  output logic       stall
);

  issue_t         r_out;
  issue_t         w_next;
  reg_addr_t      r_sb_addr [1:LAT-1];
  logic [1:LAT-1] r_sb_we;
  quad_t          w_rf_a, w_rf_b, w_rf_c;
  logic           w_hazard;

  spu_regfile u_regfile (
    .clk     (clk),
    .reset   (reset),
    .ra_addr (ra_addr),
    .rb_addr (rb_addr),
    .rc_addr (rc_addr),
    .ra_data (w_rf_a),
    .rb_data (w_rf_b),
    .rc_data (w_rf_c),
    .we      (reg_write_int),
    .wa      (rt_addr_int),
    .wd      (rt_int)
  );

  // Scoreboard entry 0 is the output register itself; older slots follow.
  always_comb begin
    w_hazard = src_hit(ra_addr, ra_use, rb_addr, rb_use, rc_addr, rc_use,
                       r_out.rt_addr, r_out.reg_write);
    for (int i = 1; i < LAT; i++) begin
      w_hazard = w_hazard | src_hit(ra_addr, ra_use, rb_addr, rb_use, rc_addr, rc_use,
                                    r_sb_addr[i], r_sb_we[i]);
    end
  end

  assign stall = valid_dec & w_hazard;

  always_comb begin
    w_next    = '0;
    w_next.op = NOP_OP;
    if (valid_dec && !w_hazard) begin
      w_next.op        = op_dec;
      w_next.format    = format_dec;
      w_next.rt_addr   = rt_addr_dec;
      w_next.imm       = imm_dec;
      w_next.reg_write = reg_write_dec;
      w_next.ra = fwd_sel(ra_addr, reg_write_wb, rt_addr_wb, rt_wb,
                          reg_write_int, rt_addr_int, rt_int, w_rf_a);
      w_next.rb = fwd_sel(rb_addr, reg_write_wb, rt_addr_wb, rt_wb,
                          reg_write_int, rt_addr_int, rt_int, w_rf_b);
      w_next.rc = fwd_sel(rc_addr, reg_write_wb, rt_addr_wb, rt_wb,
                          reg_write_int, rt_addr_int, rt_int, w_rf_c);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out   <= '0;
      r_sb_we <= '0;
      for (int i = 1; i < LAT; i++) r_sb_addr[i] <= '0;
    end else begin
      r_out        <= w_next;
      r_sb_addr[1] <= r_out.rt_addr;
      r_sb_we[1]   <= r_out.reg_write;
      for (int i = 2; i < LAT; i++) begin
        r_sb_addr[i] <= r_sb_addr[i-1];
        r_sb_we[i]   <= r_sb_we[i-1];
      end
    end
  end

  assign op        = r_out.op;
  assign format    = r_out.format;
  assign rt_addr   = r_out.rt_addr;
  assign ra        = r_out.ra;
  assign rb        = r_out.rb;
  assign rc        = r_out.rc;
  assign imm       = r_out.imm;
  assign reg_write = r_out.reg_write;

endmodule
`default_nettype wire

// File: tb/tb_rf_fwd_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_rf_fwd_stage
// Description : Self-checking bench for rf_fwd_stage against an in-bench
//               model of issued instructions and register contents.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rf_fwd_stage;

  localparam int LAT = 6;
  typedef logic [127:0] q_t;
  typedef struct {
    logic [6:0] addr;
    bit         we;
    q_t         data;
  } ent_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        valid_dec, ra_use, rb_use, rc_use, reg_write_dec;
  logic [10:0] op_dec;
  logic [2:0]  format_dec;
  logic [6:0]  rt_addr_dec, ra_addr, rb_addr, rc_addr;
  logic [17:0] imm_dec;
  q_t          rt_wb, rt_int;
  logic [6:0]  rt_addr_wb, rt_addr_int;
  logic        reg_write_wb, reg_write_int;
  logic [10:0] op;
  logic [2:0]  format;
  logic [6:0]  rt_addr;
  q_t          ra, rb, rc;
  logic [17:0] imm;
  logic        reg_write, stall;

  rf_fwd_stage #(.LAT(LAT)) dut (
    .clk(clk), .reset(reset), .valid_dec(valid_dec), .op_dec(op_dec),
    .format_dec(format_dec), .rt_addr_dec(rt_addr_dec), .ra_addr(ra_addr),
    .rb_addr(rb_addr), .rc_addr(rc_addr), .ra_use(ra_use), .rb_use(rb_use),
    .rc_use(rc_use), .imm_dec(imm_dec), .reg_write_dec(reg_write_dec),
    .rt_wb(rt_wb), .rt_addr_wb(rt_addr_wb), .reg_write_wb(reg_write_wb),
    .rt_int(rt_int), .rt_addr_int(rt_addr_int), .reg_write_int(reg_write_int),
    .op(op), .format(format), .rt_addr(rt_addr), .ra(ra), .rb(rb), .rc(rc),
    .imm(imm), .reg_write(reg_write), .stall(stall)
  );

  always #5 clk = ~clk;

  // Model: architectural registers plus the list of issue slots, newest first.
  q_t   m_rf [128];
  ent_t pipe [$];
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   auto_exec = 1'b0;

  task automatic chk(input string name, input q_t act, input q_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    foreach (m_rf[i]) m_rf[i] = '0;
    pipe.delete();
    repeat (LAT + 2) pipe.push_back(ent_t'{addr: 7'd0, we: 1'b0, data: '0});
  endtask

  function automatic bit busy(input logic [6:0] a, input logic u);
    if (!u) return 1'b0;
    for (int k = 0; k < LAT; k++)
      if (pipe[k].we && pipe[k].addr == a) return 1'b1;
    return 1'b0;
  endfunction

  function automatic q_t resolve(input logic [6:0] a);
    if (reg_write_wb && rt_addr_wb == a) return rt_wb;
    if (reg_write_int && rt_addr_int == a) return rt_int;
    return m_rf[a];
  endfunction

  task automatic chk_zero(input string tag);
    chk({tag, "_op"}, 128'(op), '0);
    chk({tag, "_fmt"}, 128'(format), '0);
    chk({tag, "_rt"}, 128'(rt_addr), '0);
    chk({tag, "_ra"}, ra, '0);
    chk({tag, "_rb"}, rb, '0);
    chk({tag, "_rc"}, rc, '0);
    chk({tag, "_imm"}, 128'(imm), '0);
    chk({tag, "_we"}, 128'(reg_write), '0);
    chk({tag, "_stall"}, 128'(stall), '0);
  endtask

  // One cycle: entered and left at posedge+1 with decode inputs already set.
  task automatic step(output bit st);
    bit   exp_st, iss;
    q_t   ea, eb, ec;
    ent_t e;
    if (auto_exec) begin
      pipe[LAT].data = {$urandom, $urandom, $urandom, $urandom};
      rt_wb  = pipe[LAT].data;   rt_addr_wb  = pipe[LAT].addr;   reg_write_wb  = pipe[LAT].we;
      rt_int = pipe[LAT+1].data; rt_addr_int = pipe[LAT+1].addr; reg_write_int = pipe[LAT+1].we;
    end
    exp_st = valid_dec && (busy(ra_addr, ra_use) || busy(rb_addr, rb_use) || busy(rc_addr, rc_use));
    #4;
    chk("stall", 128'(stall), 128'(exp_st));
    iss = valid_dec && !exp_st;
    ea = resolve(ra_addr);
    eb = resolve(rb_addr);
    ec = resolve(rc_addr);
    @(posedge clk);
    if (reg_write_int) m_rf[rt_addr_int] = rt_int;
    e.addr = iss ? rt_addr_dec : 7'd0;
    e.we   = iss && reg_write_dec;
    e.data = '0;
    pipe.push_front(e);
    void'(pipe.pop_back());
    #1;
    chk("op", 128'(op), iss ? 128'(op_dec) : '0);
    chk("format", 128'(format), iss ? 128'(format_dec) : '0);
    chk("rt_addr", 128'(rt_addr), iss ? 128'(rt_addr_dec) : '0);
    chk("imm", 128'(imm), iss ? 128'(imm_dec) : '0);
    chk("reg_write", 128'(reg_write), 128'(iss && reg_write_dec));
    chk("ra", ra, iss ? ea : '0);
    chk("rb", rb, iss ? eb : '0);
    chk("rc", rc, iss ? ec : '0);
    st = exp_st;
  endtask

  task automatic clear_dec();
    valid_dec = 0; op_dec = '0; format_dec = '0; rt_addr_dec = '0; imm_dec = '0;
    ra_addr = '0; rb_addr = '0; rc_addr = '0; ra_use = 0; rb_use = 0; rc_use = 0;
    reg_write_dec = 0;
  endtask

  task automatic clear_exec();
    rt_wb = '0; rt_addr_wb = '0; reg_write_wb = 0;
    rt_int = '0; rt_addr_int = '0; reg_write_int = 0;
  endtask

  localparam q_t K_R5  = 128'h0123456789ABCDEF0123456789ABCDEF;
  localparam q_t C_FWD = 128'hC0FFEE00_11112222_33334444_DEADBEEF;
  localparam q_t V_A   = 128'hAAAA0000_AAAA0000_AAAA0000_AAAA0007;
  localparam q_t V_B   = 128'hBBBB1111_BBBB1111_BBBB1111_BBBB0007;

  initial begin
    bit st;
    int cnt;
    clear_dec();
    clear_exec();
    model_reset();

    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset");
    reset = 0;

    valid_dec = 1; ra_addr = 7'd9; ra_use = 1; op_dec = 11'h5;
    step(st);
    chk("ra_after_reset", ra, '0);

    clear_dec();
    reg_write_int = 1; rt_addr_int = 7'd5; rt_int = K_R5;
    step(st);
    clear_exec();
    step(st);
    valid_dec = 1; ra_addr = 7'd5; ra_use = 1; op_dec = 11'h21;
    step(st);
    chk("ra_r5", ra, K_R5);
    chk("stall_r5", 128'(st), '0);

    clear_dec();
    valid_dec = 1; rt_addr_dec = 7'd3; reg_write_dec = 1; op_dec = 11'h40;
    step(st);
    rt_addr_dec = 7'd10; reg_write_dec = 0; rb_addr = 7'd3; rb_use = 1; op_dec = 11'h41;
    cnt = 0;
    for (int k = 1; k <= LAT + 3; k++) begin
      if (k == LAT + 1) begin
        rt_wb = C_FWD; rt_addr_wb = 7'd3; reg_write_wb = 1;
      end else begin
        clear_exec();
      end
      step(st);
      if (!st) break;
      cnt++;
    end
    chk("stall_cycles", 128'(cnt), 128'(LAT));
    chk("rb_fwd", rb, C_FWD);
    clear_exec();
    clear_dec();
    repeat (LAT) step(st);

    valid_dec = 1; rc_addr = 7'd7; rc_use = 1; op_dec = 11'h52;
    rt_int = V_A; rt_addr_int = 7'd7; reg_write_int = 1;
    rt_wb  = V_B; rt_addr_wb  = 7'd7; reg_write_wb  = 1;
    step(st);
    chk("rc_same_cycle", rc, V_B);
    clear_exec();
    clear_dec();
    valid_dec = 1; ra_addr = 7'd7; ra_use = 1; op_dec = 11'h53;
    step(st);
    chk("rf_holds_a", ra, V_A);

    clear_dec();
    valid_dec = 1; rt_addr_dec = 7'd12; reg_write_dec = 1; op_dec = 11'h60;
    step(st);
    rt_addr_dec = 7'd13; ra_addr = 7'd12; ra_use = 0; op_dec = 11'h61;
    step(st);
    chk("unused_no_stall", 128'(st), '0);
    chk("unused_issued_rt", 128'(rt_addr), 128'(7'd13));

    clear_dec();
    valid_dec = 1; rt_addr_dec = 7'd20; reg_write_dec = 1; op_dec = 11'h70;
    step(st);
    rt_addr_dec = 7'd21; ra_addr = 7'd20; ra_use = 1; op_dec = 11'b01111000100;
    step(st);
    chk("stall_before_reset", 128'(st), 128'(1));
    #2;
    reset = 1;
    #1;
    chk_zero("mid_reset");
    model_reset();
    @(posedge clk);
    #1;
    reset = 0;
    step(st);
    chk("post_reset_op", 128'(op), 128'(11'b01111000100));
    chk("post_reset_stall", 128'(st), '0);

    auto_exec = 1;
    st = 0;
    for (int n = 0; n < 500; n++) begin
      if (!(st && valid_dec)) begin
        valid_dec     = ($urandom_range(0, 9) != 0);
        op_dec        = 11'($urandom);
        format_dec    = 3'($urandom);
        imm_dec       = 18'($urandom);
        rt_addr_dec   = 7'($urandom_range(0, 7));
        ra_addr       = 7'($urandom_range(0, 7));
        rb_addr       = 7'($urandom_range(0, 7));
        rc_addr       = 7'($urandom_range(0, 7));
        ra_use        = 1'($urandom);
        rb_use        = 1'($urandom);
        rc_use        = 1'($urandom);
        reg_write_dec = ($urandom_range(0, 3) != 0);
      end
      step(st);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/rf_fwd_stage.md
# rf_fwd_stage

Register-fetch/forwarding stage directly upstream of the single-precision execution unit. Holds the 128×128-bit SPU register file and reads three sources per instruction. Forwards in-flight results from the unit's stage-6 and stage-7 outputs, and stalls decode on unresolvable RAW hazards. Registers the exact operand/control bundle the execution unit consumes: `op`, `format`, `rt_addr`, `ra`, `rb`, `rc`, `imm`, `reg_write`.

## Interface
- `LAT`, default 6: edges from issue (capture into output register) until the result is present on `rt_wb`; range 2..8.
- `clk`  in  1  clock, all state on rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `valid_dec`  in  1  decode presents an instruction.
- `op_dec`  in  [0:10]  decoded opcode.
- `format_dec`  in  [2:0]  instruction format.
- `rt_addr_dec`  in  [0:6]  destination register.
- `ra_addr`, `rb_addr`, `rc_addr`  in  [0:6] each  source registers.
- `ra_use`, `rb_use`, `rc_use`  in  1 each  source actually read (hazard qualification).
- `imm_dec`  in  [0:17]  immediate.
- `reg_write_dec`  in  1  instruction writes RT.
- `rt_wb`, `rt_addr_wb`, `reg_write_wb`  in  [0:127], [0:6], 1  stage-6 forward tap, age LAT.
- `rt_int`, `rt_addr_int`, `reg_write_int`  in  [0:127], [0:6], 1  stage-7 result, age LAT+1; sole register-file write port.
- `op`, `format`, `rt_addr`, `ra`, `rb`, `rc`, `imm`, `reg_write`  out  [0:10], [2:0], [0:6], [0:127]×3, [0:17], 1  registered bundle to the execution unit.
- `stall`  out  1  combinational; decode holds its inputs while high.

## Operation
- Register file: 128 entries × 128 bits. All entries are real; there is no hardwired-zero register. Written at the clock edge when `reg_write_int`=1.
- Operand select per source, highest priority first:
  1. `rt_wb`, if `reg_write_wb` and address match.
  2. `rt_int`, if `reg_write_int` and address match (same-cycle write bypass).
  3. Register-file contents.
- Scoreboard: LAT entries of {rt_addr, reg_write}. Entry 0 mirrors the output register; entry i is the slot issued i edges ago. Shifts every edge. A bubble enters as reg_write=0.
- Hazard: `stall` = `valid_dec` AND some used source equals a scoreboard entry's rt_addr with reg_write=1. Unused sources never stall.
- Issue (`valid_dec` & !`stall`) at an edge: output register loads the decode bundle and resolved operands.
- Bubble (`stall` or !`valid_dec`) at an edge: output register loads `op`=0 (nop), `reg_write`=0, `rt_addr`=0, operands 0, `format`=0, `imm`=0.

## Timing
- Reset value of every output is 0, including `stall` (scoreboard clear). Register file and scoreboard are cleared asynchronously. Reset asserted mid-stall discards the stalled instruction; decode re-presents it after reset.
- Issue latency is 1 edge: decode cycle c, bundle on outputs after edge c.
- A consumer immediately behind its producer stalls exactly LAT cycles. It issues in the cycle the producer's result is on `rt_wb`, and takes `ra`/`rb`/`rc` from the forward.
- Producer-to-consumer distance d ≥ LAT: no stall.
- Distance LAT+1: value comes from the `rt_int` bypass.
- Distance > LAT+1: value comes from the register file.
- The same address on `rt_wb` and `rt_int` in one cycle selects `rt_wb`, the younger value.
- The scoreboard has no wrap: it is a pure shift register, and entries age out after LAT edges.

## Structure
- `spu_pkg` holds:
  - `reg_addr_t` [0:6] and `quad_t` [0:127];
  - `NOP_OP`=11'b0;
  - default `LAT`.
- The execution unit imports the same package.
- One sub-module, `spu_regfile`: 128×128 storage with three combinational read ports, one write port, async reset. Forward muxing and scoreboard stay in `rf_fwd_stage`.

## Test plan
- Reset → all outputs 0, `stall`=0. A read of any register after reset → `ra`=0.
- Write `rt_int`=128'h0123…CDEF to `$r5` (`reg_write_int`=1). Two cycles later, issue with `ra_addr`=5 → `ra`=128'h0123…CDEF, `stall`=0.
- Issue a producer of `$r3`, then immediately a consumer with `rb_addr`=3:
  - `stall`=1 for exactly LAT=6 cycles;
  - the consumer then issues with `rb` equal to the value driven on `rt_wb` with `rt_addr_wb`=3.
- Same-cycle test: `rt_int` writes `$r7`=A while `rt_wb` forwards `$r7`=B, and decode reads `rc_addr`=7 → `rc`=B. Next cycle the register file holds A.
- Consumer with `ra_use`=0 and `ra_addr` matching an in-flight destination → `stall`=0 and issues immediately.
- Stall active with `op_dec`=11'b01111000100, then assert `reset` → outputs 0 and scoreboard clear. After reset, the same instruction issues in one cycle.
